// File: rtl/seq_det_pkg.sv
// Shared constants and elaboration-time helpers for the serial pattern detector.
// Holds the KMP-style NEXT table, the match table and the NEXT_MATCH builders.
package seq_det_pkg;

    localparam int         MAX_W           = 16;
    localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

    // Entry index is {state, x}; entries are wide enough for the largest state.
    typedef logic [4:0]             nstate_t;
    typedef nstate_t [2*MAX_W-1:0]  next_tbl_t;
    typedef logic [2*MAX_W-1:0]     match_tbl_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Longest pattern prefix (shorter than the pattern) that ends the history
    // "first k pattern bits followed by x"; also covers the border after a match.
    function automatic next_tbl_t build_next(input logic [MAX_W-1:0] pat, input int pat_w);
        next_tbl_t      tbl;
        logic [MAX_W:0] h;
        bit             ok;
        int             best;
        tbl = '0;
        for (int k = 0; k < MAX_W; k++) begin
            for (int xb = 0; xb < 2; xb++) begin
                if (k < pat_w) begin
                    h = '0;
                    for (int j = 0; j < k; j++) begin
                        h[j] = pat[pat_w-1-j];
                    end
                    h[k] = (xb != 0);
                    best = 0;
                    for (int l = 1; l < pat_w; l++) begin
                        if (l <= k + 1) begin
                            ok = 1'b1;
                            for (int m = 0; m < l; m++) begin
                                if (h[k+1-l+m] != pat[pat_w-1-m]) begin
                                    ok = 1'b0;
                                end
                            end
                            if (ok) begin
                                best = l;
                            end
                        end
                    end
                    tbl[k*2+xb] = nstate_t'(best);
                end
            end
        end
        return tbl;
    endfunction

    function automatic match_tbl_t build_match(input logic [MAX_W-1:0] pat, input int pat_w);
        match_tbl_t tbl;
        tbl = '0;
        tbl[(pat_w-1)*2 + (pat[0] ? 1 : 0)] = 1'b1;
        return tbl;
    endfunction

    function automatic nstate_t next_match(input next_tbl_t tbl, input logic [MAX_W-1:0] pat,
                                           input int pat_w, input bit overlap);
        nstate_t r;
        if (overlap) begin
            r = tbl[(pat_w-1)*2 + (pat[0] ? 1 : 0)];
        end else begin
            r = 5'd0;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_det_cnt.sv
// Saturating match counter with clear taking priority over increment.
module seq_det_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_r;

    // Counter register: reset/clear to zero, otherwise count up and stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_r <= '0;
        end else if (inc && !(&cnt_r)) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/seq_detector.sv
// Parametrised serial pattern detector with KMP recovery and registered det pulse.
// Optional match counter enabled by defining SEQ_DET_CNT_EN.
module seq_detector
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEFAULT_PATTERN),
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8,
    localparam int              SW      = clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             x_valid,
    input  logic             cnt_clr,
    output logic             det,
    output logic [SW-1:0]    state,
    output logic [CNT_W-1:0] match_cnt
);

    localparam logic [MAX_W-1:0] PAT_EXT    = MAX_W'(PATTERN);
    localparam next_tbl_t        NEXT       = build_next(PAT_EXT, PAT_W);
    localparam match_tbl_t       MATCH      = build_match(PAT_EXT, PAT_W);
    localparam nstate_t          NEXT_MATCH = next_match(NEXT, PAT_EXT, PAT_W, OVERLAP);

    logic [SW-1:0] state_r;
    logic [SW-1:0] next_s;
    logic [4:0]    idx_s;
    logic          match_s;
    logic          det_r;

    // Next-state and match lookup, indexed by {state, x}.
    always_comb begin
        idx_s   = 5'({state_r, x});
        match_s = MATCH[idx_s];
        if (match_s) begin
            next_s = NEXT_MATCH[SW-1:0];
        end else begin
            next_s = NEXT[idx_s][SW-1:0];
        end
    end

    // State and det registers; invalid cycles hold state and drop det.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= '0;
            det_r   <= 1'b0;
        end else if (x_valid) begin
            state_r <= next_s;
            det_r   <= match_s;
        end else begin
            state_r <= state_r;
            det_r   <= 1'b0;
        end
    end

    assign state = state_r;
    assign det   = det_r;

`ifdef SEQ_DET_CNT_EN
    logic inc_s;
    assign inc_s = x_valid & match_s;

    seq_det_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (inc_s),
        .clr (cnt_clr),
        .cnt (match_cnt)
    );
`else
    logic unused_cnt_clr_s;
    assign unused_cnt_clr_s = cnt_clr;
    assign match_cnt        = '0;
`endif

endmodule

// File: doc/seq_detector.md
# seq_detector

Parametrised serial pattern-detector FSM: samples one bit per qualified clock and emits a registered one-cycle pulse when the last PAT_W bits equal PATTERN. Partial-match recovery and overlap handling follow the KMP failure function, so no match is ever missed. It generalises the team's fixed three-state Moore FSMs to a configurable pattern, a qualified input, selectable overlap and an optional match counter. It sits directly behind serial-line front ends, and its outputs feed control logic.

## Interface
- PAT_W, 4: pattern length in bits; legal range 2..16
- PATTERN, 4'b1011: target sequence; PATTERN[PAT_W-1] is the first bit received
- OVERLAP, 1: 1 means the bits of a match may start the next match; 0 means detection restarts from empty after a match
- CNT_W, 8: match counter width; legal range 1..32
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- x  input  1  serial data bit
- x_valid  input  1  x is sampled only when high
- cnt_clr  input  1  synchronous clear of match_cnt
- det  output  1  registered match pulse
- state  output  SW  current matched-prefix length 0..PAT_W-1; SW = clog2(PAT_W+1)
- match_cnt  output  CNT_W  saturating count of matches

## Operation
- The FSM has states S0..S(PAT_W-1); Sk means the most recent k valid bits equal the first k pattern bits.
- On an edge with x_valid=1 in state Sk:
  - If x equals pattern bit k (PATTERN[PAT_W-1-k]) and k+1 < PAT_W, go to S(k+1).
  - If x equals pattern bit k and k+1 = PAT_W, this is a match: det<=1. Next state is NEXT_MATCH: with OVERLAP=1, the longest proper border of PATTERN; with OVERLAP=0, S0.
  - If x does not equal pattern bit k, go to the longest prefix of the pattern that is a suffix of the received history plus x. This comes from the elaboration-time table NEXT[k][x].
- On an edge with x_valid=0: state holds and det<=0.
- det is never high on two cycles without an intervening valid match edge. Each match produces exactly one pulse.
- match_cnt:
  - Increments on every det pulse and saturates at all-ones.
  - cnt_clr=1 forces it to 0.
  - If cnt_clr and a match occur on the same edge, clear wins and the result is 0.
- rst: state<=S0, det<=0, match_cnt<=0. rst overrides every other input, including a mid-pattern state.
- All next-state arithmetic is combinational table lookup. No runtime comparators wider than 1 bit.

## Timing
- Latency is one cycle: det is high for exactly the cycle that follows the edge sampling the final matching bit.
- state and match_cnt update on the same edge as det.
- Throughput is one bit per cycle. Back-to-back x_valid is fully supported, and with OVERLAP=1 a match is possible on consecutive cycles if the pattern permits it (e.g. PATTERN=2'b11).
- Gaps in x_valid are transparent: the history is preserved across any gap length.
- Reset takes effect on the first clk edge with rst=1. Outputs are defined from that edge onward.

## Configuration
- SEQ_DET_CNT_EN defined: the match_cnt register and the cnt_clr logic are present as described above.
- SEQ_DET_CNT_EN undefined: match_cnt is tied to 0, cnt_clr is ignored, and no counter flops are synthesised. FSM and det behaviour are identical in both builds.

## Structure
- seq_det_pkg holds:
  - the state-width function clog2
  - the constant function that builds the NEXT table and NEXT_MATCH from PATTERN, PAT_W and OVERLAP
  - the default pattern constant
- seq_det_cnt is a sub-module: a CNT_W-bit saturating counter with clear-priority. It is instantiated only under SEQ_DET_CNT_EN.
- The top level holds the state register, the table lookup and the det register.

## Test plan
- Reset, defaults: rst held for 2 cycles mid-stream, then released -> state=0, det=0, match_cnt=0. A first bit 1 moves state to 1.
- Overlap on: input 1,0,1,1,0,1,1 (all valid) -> det pulses after bits 4 and 7; match_cnt=2; state=1 at end.
- Overlap off: the same stream with OVERLAP=0 -> a single det after bit 4; match_cnt=1; state=1 at end.
- Mismatch fallback: PATTERN=4'b1101, input 1,1,1,0,1 -> 1,1,1 leaves state at 2, not 0; det after bit 5; no false det earlier.
- Valid gaps: stream 1,0,1,1 with x_valid=0 for 5 cycles between each pair of bits, and x toggling randomly while invalid -> exactly one det, one cycle after the valid edge sampling bit 4.
- Counter: CNT_W=2 with 5 matches -> match_cnt saturates at 3. Asserting cnt_clr on a match edge gives match_cnt=0 and det=1. Without SEQ_DET_CNT_EN, match_cnt stays 0 throughout.
